// File: rtl/silife_pkg.sv
// Shared definitions for the SiLife scan controller slice.
// Contents: config register addresses, CTRL register bit positions and the
// controller FSM state type.
package silife_pkg;

  // Config bus register map
  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_CYCLES  = 2'd1;
  localparam logic [1:0] ADDR_FPS     = 2'd2;
  localparam logic [1:0] ADDR_GEN_CLR = 2'd3;

  // CTRL register bit positions
  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_INVERT = 1;
  localparam int unsigned CTRL_AUTO   = 2;
  localparam int unsigned CTRL_SINGLE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    STEP = 2'd2
  } state_e;

endpackage

// File: rtl/silife_frame_detect.sv
// Frame wrap detector for the SiLife scanner.
// Remembers the previous row and flags the cycle in which the row index
// wraps from HEIGHT-1 back to 0.
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   clear_i  holds prev_row at 0 (asserted while the scanner is in reset)
//   row_i    current row from the scanner
//   wrap_o   combinational wrap flag (prev_row == HEIGHT-1 && row == 0)
module silife_frame_detect #(
  parameter  int HEIGHT   = 8,
  localparam int ROW_BITS = $clog2(HEIGHT)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clear_i,
  input  logic [ROW_BITS-1:0] row_i,
  output logic                wrap_o
);

  logic [ROW_BITS-1:0] prev_row_q, prev_row_d;

  // Forcing prev_row to 0 while the scanner is blanked prevents a stale
  // HEIGHT-1 from producing a false wrap when the scanner restarts at row 0.
  always_comb begin
    prev_row_d = row_i;
    if (clear_i) prev_row_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) prev_row_q <= '0;
    else         prev_row_q <= prev_row_d;
  end

  assign wrap_o = (prev_row_q == ROW_BITS'(HEIGHT - 1)) && (row_i == '0);

endmodule

// File: rtl/silife_scan_ctrl.sv
// SiLife scan/generation sequencing controller.
// Holds the scanner configuration, detects completed frames and schedules
// life-engine steps (every N frames or on a single-step command) through a
// req/ack handshake, blanking the display while a step runs.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   cfg_we/cfg_addr/cfg_wdata  write-only host config bus
//   row_select                 current row from the scanner
//   step_ack                   engine completion pulse
//   scan_reset                 scanner reset / blank (1 = blanked)
//   scan_cycles, scan_invert   scanner configuration
//   step_req, busy             high while a step is in progress
//   frame_done                 one-cycle pulse per completed frame
//   gen_count                  completed generations (wraps at 16 bits)
module silife_scan_ctrl
  import silife_pkg::*;
#(
  parameter  int HEIGHT   = 8,
  parameter  int FPS_BITS = 8,
  localparam int ROW_BITS = $clog2(HEIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_addr,
  input  logic [15:0]         cfg_wdata,
  input  logic [ROW_BITS-1:0] row_select,
  input  logic                step_ack,
  output logic                scan_reset,
  output logic [15:0]         scan_cycles,
  output logic                scan_invert,
  output logic                step_req,
  output logic                frame_done,
  output logic [15:0]         gen_count,
  output logic                busy
);

  state_e              state_q, state_d;
  logic                enable_q, enable_d;
  logic                invert_q, invert_d;
  logic                auto_q, auto_d;
  logic                pending_q, pending_d;
  logic [15:0]         cycles_q, cycles_d;
  logic [FPS_BITS-1:0] fps_q, fps_d;
  logic [FPS_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [15:0]         gen_q, gen_d;
  logic                frame_done_q, frame_done_d;

  logic                wrap;
  logic [FPS_BITS-1:0] fps_eff;
  logic [FPS_BITS:0]   cnt_inc;

  silife_frame_detect #(
    .HEIGHT(HEIGHT)
  ) u_frame_detect (
    .clk_i  (clk),
    .reset_i(reset),
    .clear_i(scan_reset),
    .row_i  (row_select),
    .wrap_o (wrap)
  );

  assign fps_eff = (fps_q == '0) ? FPS_BITS'(1) : fps_q;
  // One extra bit so frame_cnt+1 cannot wrap before the comparison.
  assign cnt_inc = {1'b0, frame_cnt_q} + (FPS_BITS + 1)'(1);

  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    invert_d     = invert_q;
    auto_d       = auto_q;
    pending_d    = pending_q;
    cycles_d     = cycles_q;
    fps_d        = fps_q;
    frame_cnt_d  = frame_cnt_q;
    gen_d        = gen_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pending_q)     state_d = STEP;
        else if (enable_q) state_d = SCAN;
      end
      SCAN: begin
        if (frame_done_q) frame_cnt_d = cnt_inc[FPS_BITS-1:0];
        if (pending_q) begin
          state_d = STEP;
        end else if (!enable_q) begin
          state_d     = IDLE;
          frame_cnt_d = '0;
        end else if (frame_done_q && auto_q && (cnt_inc >= {1'b0, fps_eff})) begin
          state_d     = STEP;
          frame_cnt_d = '0;
        end
      end
      STEP: begin
        if (step_ack) begin
          gen_d   = gen_q + 16'd1;
          state_d = enable_q ? SCAN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame_done only counts while the scanner is running and stays running.
    frame_done_d = wrap && (state_q == SCAN) && (state_d == SCAN);

    if ((state_q != STEP) && (state_d == STEP)) pending_d = 1'b0;

    // Config writes come last: a single_step arriving on the entry cycle
    // still re-arms pending, and GEN_CLEAR overrides a same-cycle ack.
    if (cfg_we) begin
      unique case (cfg_addr)
        ADDR_CTRL: begin
          enable_d = cfg_wdata[CTRL_ENABLE];
          invert_d = cfg_wdata[CTRL_INVERT];
          auto_d   = cfg_wdata[CTRL_AUTO];
          if (cfg_wdata[CTRL_SINGLE]) pending_d = 1'b1;
        end
        ADDR_CYCLES:  cycles_d = cfg_wdata;
        ADDR_FPS:     fps_d    = cfg_wdata[FPS_BITS-1:0];
        ADDR_GEN_CLR: gen_d    = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      invert_q     <= 1'b0;
      auto_q       <= 1'b0;
      pending_q    <= 1'b0;
      cycles_q     <= '0;
      fps_q        <= FPS_BITS'(1);
      frame_cnt_q  <= '0;
      gen_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      invert_q     <= invert_d;
      auto_q       <= auto_d;
      pending_q    <= pending_d;
      cycles_q     <= cycles_d;
      fps_q        <= fps_d;
      frame_cnt_q  <= frame_cnt_d;
      gen_q        <= gen_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign scan_reset  = (state_q != SCAN);
  assign step_req    = (state_q == STEP);
  assign busy        = (state_q == STEP);
  assign scan_cycles = cycles_q;
  assign scan_invert = invert_q;
  assign frame_done  = frame_done_q;
  assign gen_count   = gen_q;

endmodule
